// File: rtl/l2_evict_ctrl_if.sv
// Miss/eviction bus of the L2 controller: miss handshake, hit updates,
// LRU tracker port, tag/data array strobes and the memory line port.
interface l2_evict_ctrl_if #(
  parameter int unsigned s_index  = 3,
  parameter int unsigned num_ways = 2,
  parameter int unsigned s_tag    = 24,
  parameter int unsigned width    = $clog2(num_ways)
);
  logic               miss_req;
  logic [s_index-1:0] miss_index;
  logic [s_tag-1:0]   miss_tag;
  logic               miss_write;
  logic               miss_done;
  logic [width-1:0]   miss_way;
  logic               hit;
  logic [s_index-1:0] hit_index;
  logic [width-1:0]   hit_way;
  logic               hit_write;
  logic               lru_read;
  logic [s_index-1:0] lru_rindex;
  logic [width-1:0]   lru_way;
  logic               lru_load;
  logic [s_index-1:0] lru_windex;
  logic [width-1:0]   lru_recent_way;
  logic [s_tag-1:0]   victim_tag;
  logic               tag_we;
  logic [width-1:0]   cur_way;
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_addr;
  logic               mem_resp;
  logic               fill_we;

  // Cache front end, LRU tracker, arrays and memory side
  modport master (
    output miss_req, miss_index, miss_tag, miss_write,
    output hit, hit_index, hit_way, hit_write,
    output lru_way, victim_tag, mem_resp,
    input  miss_done, miss_way, lru_read, lru_rindex, lru_load, lru_windex,
    input  lru_recent_way, tag_we, cur_way, mem_read, mem_write, mem_addr, fill_we
  );

  // Eviction controller side
  modport slave (
    input  miss_req, miss_index, miss_tag, miss_write,
    input  hit, hit_index, hit_way, hit_write,
    input  lru_way, victim_tag, mem_resp,
    output miss_done, miss_way, lru_read, lru_rindex, lru_load, lru_windex,
    output lru_recent_way, tag_we, cur_way, mem_read, mem_write, mem_addr, fill_we
  );
endinterface

// File: rtl/l2_evict_ctrl.sv
// L2 miss/eviction controller: LRU victim read, dirty writeback, line fill, LRU update.
// Optional L2_EVICT_INVALID_FIRST_EN: prefer the lowest invalid way over the LRU victim.
module l2_evict_ctrl #(
  parameter int unsigned s_index  = 3,
  parameter int unsigned num_ways = 2,
  parameter int unsigned s_tag    = 24,
  parameter int unsigned s_offset = 5,
  parameter int unsigned width    = $clog2(num_ways)
) (
  input logic           clk,
  input logic           rst_n,
  l2_evict_ctrl_if.slave bus
);
  localparam int unsigned num_sets = 2 ** s_index;

  typedef enum logic [2:0] {IDLE, LRU_RD, VICTIM, WB, FILL, DONE} state_e;

  state_e                             state_q, state_d;
  logic [width-1:0]                   cur_way_q, cur_way_d;
  logic [num_sets-1:0][num_ways-1:0]  valid_q, valid_d;
  logic [num_sets-1:0][num_ways-1:0]  dirty_q, dirty_d;
  logic [width-1:0]                   victim_way_c;

  // Victim choice for the VICTIM cycle
  always_comb begin
    victim_way_c = bus.lru_way;
`ifdef L2_EVICT_INVALID_FIRST_EN
    for (int w = int'(num_ways) - 1; w >= 0; w--) begin
      if (!valid_q[bus.miss_index][width'(w)]) victim_way_c = width'(w);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_way_q <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_way_q <= cur_way_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
    end
  end

  assign bus.cur_way = cur_way_q;

  // Next state, valid/dirty updates and state-decoded strobes
  always_comb begin
    state_d            = state_q;
    cur_way_d          = cur_way_q;
    valid_d            = valid_q;
    dirty_d            = dirty_q;
    bus.miss_done      = 1'b0;
    bus.miss_way       = '0;
    bus.lru_read       = 1'b0;
    bus.lru_rindex     = '0;
    bus.lru_load       = 1'b0;
    bus.lru_windex     = '0;
    bus.lru_recent_way = '0;
    bus.tag_we         = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_addr       = '0;
    bus.fill_we        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.hit) begin
          bus.lru_load       = 1'b1;
          bus.lru_windex     = bus.hit_index;
          bus.lru_recent_way = bus.hit_way;
          if (bus.hit_write) dirty_d[bus.hit_index][bus.hit_way] = 1'b1;
        end
        if (bus.miss_req) state_d = LRU_RD;
      end
      LRU_RD: begin
        bus.lru_read   = 1'b1;
        bus.lru_rindex = bus.miss_index;
        state_d        = VICTIM;
      end
      VICTIM: begin
        cur_way_d = victim_way_c;
        if (valid_q[bus.miss_index][victim_way_c] && dirty_q[bus.miss_index][victim_way_c])
          state_d = WB;
        else
          state_d = FILL;
      end
      WB: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {bus.victim_tag, bus.miss_index, s_offset'(0)};
        if (bus.mem_resp) begin
          dirty_d[bus.miss_index][cur_way_q] = 1'b0;
          state_d                            = FILL;
        end
      end
      FILL: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {bus.miss_tag, bus.miss_index, s_offset'(0)};
        if (bus.mem_resp) begin
          bus.fill_we                        = 1'b1;
          bus.tag_we                         = 1'b1;
          valid_d[bus.miss_index][cur_way_q] = 1'b1;
          dirty_d[bus.miss_index][cur_way_q] = bus.miss_write;
          state_d                            = DONE;
        end
      end
      DONE: begin
        bus.miss_done      = 1'b1;
        bus.miss_way       = cur_way_q;
        bus.lru_load       = 1'b1;
        bus.lru_windex     = bus.miss_index;
        bus.lru_recent_way = cur_way_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_l2_evict_ctrl.sv
// Randomized self-checking bench for l2_evict_ctrl against a per-set/per-way line model.
`timescale 1ns/1ps
module tb_l2_evict_ctrl;
  localparam int s_index  = 3;
  localparam int num_ways = 2;
  localparam int s_tag    = 24;
  localparam int s_offset = 5;
  localparam int width    = 1;
  localparam int num_sets = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_evict_ctrl_if #(.s_index(s_index), .num_ways(num_ways), .s_tag(s_tag), .width(width)) bus();

  l2_evict_ctrl #(.s_index(s_index), .num_ways(num_ways), .s_tag(s_tag),
                  .s_offset(s_offset), .width(width)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // External tag array the controller writes through tag_we
  logic [s_tag-1:0] tag_arr [num_sets][num_ways];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < num_sets; s++)
        for (int w = 0; w < num_ways; w++) tag_arr[s][w] <= '0;
    end else if (bus.tag_we) begin
      tag_arr[bus.miss_index][bus.cur_way] <= bus.miss_tag;
    end
  end
  assign bus.victim_tag = tag_arr[bus.miss_index][bus.cur_way];

  // Reference model of the cache lines
  bit               m_valid [num_sets][num_ways];
  bit               m_dirty [num_sets][num_ways];
  logic [s_tag-1:0] m_tag   [num_sets][num_ways];
  bit               resp_noise = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_victim(input int idx, input int lw);
`ifdef L2_EVICT_INVALID_FIRST_EN
    for (int w = 0; w < num_ways; w++) if (!m_valid[idx][w]) return w;
`endif
    return lw;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < num_sets; s++)
      for (int w = 0; w < num_ways; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
      end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_miss_done"}, 32'(bus.miss_done), 0);
    chk({pfx, "_miss_way"},  32'(bus.miss_way), 0);
    chk({pfx, "_lru_read"},  32'(bus.lru_read), 0);
    chk({pfx, "_lru_load"},  32'(bus.lru_load), 0);
    chk({pfx, "_tag_we"},    32'(bus.tag_we), 0);
    chk({pfx, "_fill_we"},   32'(bus.fill_we), 0);
    chk({pfx, "_mem_read"},  32'(bus.mem_read), 0);
    chk({pfx, "_mem_write"}, 32'(bus.mem_write), 0);
    chk({pfx, "_mem_addr"},  bus.mem_addr, 0);
    chk({pfx, "_cur_way"},   32'(bus.cur_way), 0);
  endtask

  task automatic do_hit(input int idx, input int way, input bit wr);
    @(negedge clk);
    bus.hit = 1'b1; bus.hit_index = s_index'(idx); bus.hit_way = width'(way); bus.hit_write = wr;
    bus.mem_resp = resp_noise ? 1'($urandom_range(1)) : 1'b0;
    #1;
    chk("hit_lru_load", 32'(bus.lru_load), 1);
    chk("hit_windex", 32'(bus.lru_windex), 32'(idx));
    chk("hit_recent", 32'(bus.lru_recent_way), 32'(way));
    chk("hit_no_fill", 32'({bus.fill_we, bus.mem_read, bus.mem_write, bus.lru_read}), 0);
    if (wr) m_dirty[idx][way] = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0; bus.hit_write = 1'b0; bus.mem_resp = 1'b0;
  endtask

  task automatic do_miss(input int idx, input logic [s_tag-1:0] tg, input bit wr, input int lw,
                         input int dly, input bit with_hit, input int h_idx, input int h_way,
                         input bit h_wr);
    int ew, n_lru, n_fill, n_tag, wb_first, rd_first, wcnt;
    bit ewb, done, excl_bad, rix_bad, wb_moved, rd_moved, split;
    logic [31:0] ewb_addr, erd_addr, wb_addr, rd_addr;
    if (with_hit && h_wr) m_dirty[h_idx][h_way] = 1'b1;
    ew       = model_victim(idx, lw);
    ewb      = m_valid[idx][ew] && m_dirty[idx][ew];
    ewb_addr = {m_tag[idx][ew], s_index'(idx), s_offset'(0)};
    erd_addr = {tg, s_index'(idx), s_offset'(0)};
    n_lru = 0; n_fill = 0; n_tag = 0; wb_first = -1; rd_first = -1; wcnt = 0;
    done = 0; excl_bad = 0; rix_bad = 0; wb_moved = 0; rd_moved = 0; split = 0;
    wb_addr = '0; rd_addr = '0;
    @(negedge clk);
    bus.miss_req = 1'b1; bus.miss_index = s_index'(idx); bus.miss_tag = tg;
    bus.miss_write = wr; bus.lru_way = width'(lw); bus.mem_resp = 1'b0;
    if (with_hit) begin
      bus.hit = 1'b1; bus.hit_index = s_index'(h_idx); bus.hit_way = width'(h_way);
      bus.hit_write = h_wr;
    end
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      #1;
      if (with_hit && cyc == 0) begin
        chk("hm_lru_load", 32'(bus.lru_load), 1);
        chk("hm_windex", 32'(bus.lru_windex), 32'(h_idx));
        chk("hm_recent", 32'(bus.lru_recent_way), 32'(h_way));
        chk("hm_no_lru_read", 32'(bus.lru_read), 0);
      end
      if (with_hit && cyc == 1) chk("hm_lru_read_next", 32'(bus.lru_read), 1);
      if (bus.lru_read) begin
        n_lru++;
        if (bus.lru_rindex !== s_index'(idx)) rix_bad = 1;
      end
      if (bus.mem_read && bus.mem_write) excl_bad = 1;
      if (bus.mem_write) begin
        if (wb_first < 0) begin wb_first = cyc; wb_addr = bus.mem_addr; end
        else if (bus.mem_addr !== wb_addr) wb_moved = 1;
      end
      if (bus.mem_read) begin
        if (rd_first < 0) begin rd_first = cyc; rd_addr = bus.mem_addr; end
        else if (bus.mem_addr !== rd_addr) rd_moved = 1;
      end
      if (bus.fill_we) n_fill++;
      if (bus.tag_we) n_tag++;
      if (bus.fill_we !== bus.tag_we) split = 1;
      if (bus.miss_done) begin
        done = 1;
        chk("done_way", 32'(bus.miss_way), 32'(ew));
        chk("done_lru_load", 32'(bus.lru_load), 1);
        chk("done_windex", 32'(bus.lru_windex), 32'(idx));
        chk("done_recent", 32'(bus.lru_recent_way), 32'(ew));
      end
      if (!done) begin
        @(negedge clk);
        bus.hit = 1'b0; bus.hit_write = 1'b0; bus.mem_resp = 1'b0;
        if (bus.mem_read || bus.mem_write) begin
          if (wcnt >= dly) begin bus.mem_resp = 1'b1; wcnt = 0; end
          else wcnt++;
        end else if (resp_noise) begin
          bus.mem_resp = 1'($urandom_range(1));
        end
      end
    end
    chk("miss_done_seen", 32'(done), 1);
    chk("lru_read_once", 32'(n_lru), 1);
    chk("lru_rindex", 32'(rix_bad), 0);
    chk("wb_seen", 32'(wb_first >= 0), 32'(ewb));
    if (ewb) begin
      chk("wb_addr", wb_addr, ewb_addr);
      chk("wb_before_rd", 32'(wb_first < rd_first), 1);
    end
    chk("rd_addr", rd_addr, erd_addr);
    chk("mem_excl", 32'(excl_bad), 0);
    chk("addr_stable", 32'({wb_moved, rd_moved}), 0);
    chk("fill_once", 32'(n_fill), 1);
    chk("tag_once", 32'(n_tag), 1);
    chk("fill_tag_same", 32'(split), 0);
    @(negedge clk);
    bus.miss_req = 1'b0; bus.miss_write = 1'b0; bus.mem_resp = 1'b0;
    m_valid[idx][ew] = 1'b1;
    m_dirty[idx][ew] = wr;
    m_tag[idx][ew]   = tg;
  endtask

  task automatic reset_during_wb();
    int lw_d;
    bit saw;
    do_miss(6, 24'h00F00D, 1'b0, 1, 0, 1'b0, 0, 0, 1'b0);
    do_miss(6, 24'h00BEEF, 1'b1, 0, 1, 1'b0, 0, 0, 1'b0);
    lw_d = m_dirty[6][0] ? 0 : 1;
    saw = 0;
    @(negedge clk);
    bus.miss_req = 1'b1; bus.miss_index = 3'd6; bus.miss_tag = 24'h000111;
    bus.miss_write = 1'b0; bus.lru_way = width'(lw_d); bus.mem_resp = 1'b0;
    for (int cyc = 0; cyc < 12 && !saw; cyc++) begin
      #1;
      if (bus.mem_write) saw = 1;
      else @(negedge clk);
    end
    chk("rstwb_mem_write_up", 32'(bus.mem_write), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rstwb");
    bus.miss_req = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_miss(6, 24'h000222, 1'b0, lw_d, 2, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    bus.miss_req = 1'b0; bus.miss_index = '0; bus.miss_tag = '0; bus.miss_write = 1'b0;
    bus.hit = 1'b0; bus.hit_index = '0; bus.hit_way = '0; bus.hit_write = 1'b0;
    bus.lru_way = '0; bus.mem_resp = 1'b0;
    model_clear();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("post_reset");

    // Clean read miss, 5-cycle memory latency
    do_miss(3, 24'h00ABCD, 1'b0, 1, 5, 1'b0, 0, 0, 1'b0);
    // Store miss then read misses on the same way: writeback once, then clean
    do_miss(3, 24'h00ABCD, 1'b1, 1, 2, 1'b0, 0, 0, 1'b0);
    do_miss(3, 24'h001234, 1'b0, 1, 3, 1'b0, 0, 0, 1'b0);
    do_miss(3, 24'h005678, 1'b0, 1, 0, 1'b0, 0, 0, 1'b0);
    // Hit store makes a valid clean line dirty
    do_miss(5, 24'h00AAAA, 1'b0, 0, 1, 1'b0, 0, 0, 1'b0);
    do_hit(5, 0, 1'b1);
    do_miss(5, 24'h00BBBB, 1'b0, 0, 1, 1'b0, 0, 0, 1'b0);
    // Hit and miss in the same idle cycle
    do_miss(2, 24'h00CCCC, 1'b0, 1, 1, 1'b1, 4, 1, 1'b0);
    reset_during_wb();

    // Randomized traffic with stray mem_resp pulses
    resp_noise = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(2) == 0)
        do_hit(int'($urandom_range(num_sets - 1)), int'($urandom_range(num_ways - 1)),
               1'($urandom_range(1)));
      else
        do_miss(int'($urandom_range(num_sets - 1)), s_tag'($urandom),
                1'($urandom_range(1)), int'($urandom_range(num_ways - 1)),
                int'($urandom_range(4)), ($urandom_range(3) == 0),
                int'($urandom_range(num_sets - 1)), int'($urandom_range(num_ways - 1)),
                1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
